tone_sequencer: RTL and testbench

//  Parametrised successor to the buzzer song player. Walks an external score ROM and drives a square wave on speaker/buzzer.

---
 rtl/tone_sequencer.sv | 171 +++++++++++++++++
 tb/tb_tone_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Score-ROM driven square-wave sequencer with start/stop/pause, loop mode,
// per-note durations, rests and an end-of-score marker.
module tone_sequencer #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 16,
  parameter int ADDR_W   = 8,
  parameter int PERIOD_W = 20,
  parameter int DUR_W    = 4
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      pause,
  input  logic                      loop_en,
  output logic [ADDR_W-1:0]         score_addr,
  input  logic [DUR_W+PERIOD_W-1:0] score_data,
  output logic                      speaker,
  output logic                      buzzer,
  output logic                      busy,
  output logic                      done
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_cfg_err
    $error("tone_sequencer: CLK_HZ/TICK_HZ must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_PAUSED,
    S_END
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] tone_q;
  logic [DUR_W-1:0]    left_q;
  logic [PRE_W-1:0]    presc_q;
  logic                phase_q;
  logic                spk_q;
  logic                busy_q;
  logic                done_q;

  logic [DUR_W-1:0]    dur_f;
  logic [PERIOD_W-1:0] per_f;
  logic                tick;
  logic                tone_wrap;
  logic                last_note;
  logic                addr_max;

  assign dur_f     = score_data[DUR_W+PERIOD_W-1 -: DUR_W];
  assign per_f     = score_data[PERIOD_W-1:0];
  assign tick      = (presc_q == PRE_W'(DIV - 1));
  assign tone_wrap = (tone_q == period_q - PERIOD_W'(1));
  assign last_note = (left_q == DUR_W'(1));
  assign addr_max  = &addr_q;

  // phase_q carries the tone phase through a pause while spk_q is held low
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      period_q <= '0;
      tone_q   <= '0;
      left_q   <= '0;
      presc_q  <= '0;
      phase_q  <= 1'b0;
      spk_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE && stop) begin
        state_q <= S_IDLE;
        addr_q  <= '0;
        tone_q  <= '0;
        left_q  <= '0;
        presc_q <= '0;
        phase_q <= 1'b0;
        spk_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start && !stop) begin
              state_q <= S_FETCH;
              addr_q  <= '0;
              busy_q  <= 1'b1;
            end
          end
          S_FETCH: begin
            period_q <= per_f;
            left_q   <= dur_f;
            presc_q  <= '0;
            tone_q   <= '0;
            phase_q  <= 1'b0;
            spk_q    <= 1'b0;
            if (dur_f == '0) begin
              state_q <= S_END;
              done_q  <= !loop_en;
            end else begin
              state_q <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (pause) begin
              state_q <= S_PAUSED;
              spk_q   <= 1'b0;
            end else begin
              presc_q <= tick ? '0 : presc_q + PRE_W'(1);
              if (period_q != '0) begin
                if (tone_wrap) begin
                  tone_q  <= '0;
                  phase_q <= ~phase_q;
                  spk_q   <= ~phase_q;
                end else begin
                  tone_q <= tone_q + PERIOD_W'(1);
                end
              end
              if (tick) begin
                left_q <= left_q - DUR_W'(1);
                if (last_note) begin
                  spk_q <= 1'b0;
                  if (addr_max) begin
                    state_q <= S_END;
                    done_q  <= !loop_en;
                  end else begin
                    state_q <= S_FETCH;
                    addr_q  <= addr_q + ADDR_W'(1);
                  end
                end
              end
            end
          end
          S_PAUSED: begin
            if (!pause) begin
              state_q <= S_PLAY;
              spk_q   <= phase_q;
            end
          end
          S_END: begin
            addr_q <= '0;
            if (done_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_FETCH;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign score_addr = addr_q;
  assign speaker    = spk_q;
  assign buzzer     = spk_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: segment tables expanded into per-cycle
// expectations, queued on drive and compared after each clock edge.
module tb_tone_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start2, stop, pause, loop_en;
  logic [7:0] addr1, data1;
  logic       spk1, buz1, busy1, done1;
  logic [1:0] addr2;
  logic [7:0] data2;
  logic       spk2, buz2, busy2, done2;

  always #5 clk = ~clk;

  tone_sequencer #(
    .CLK_HZ(100), .TICK_HZ(10), .ADDR_W(8), .PERIOD_W(4), .DUR_W(4)
  ) u_dut (
    .sys_clk(clk), .rst(rst), .start(start1), .stop(stop),
    .pause(pause), .loop_en(loop_en), .score_addr(addr1),
    .score_data(data1), .speaker(spk1), .buzzer(buz1),
    .busy(busy1), .done(done1)
  );

  tone_sequencer #(
    .CLK_HZ(100), .TICK_HZ(10), .ADDR_W(2), .PERIOD_W(4), .DUR_W(4)
  ) u_wrap (
    .sys_clk(clk), .rst(rst), .start(start2), .stop(stop),
    .pause(pause), .loop_en(loop_en), .score_addr(addr2),
    .score_data(data2), .speaker(spk2), .buzzer(buz2),
    .busy(busy2), .done(done2)
  );

  always_comb begin
    data1 = 8'h00;
    case (addr1)
      8'd0:    data1 = {4'd2, 4'd3};
      8'd1:    data1 = {4'd1, 4'd0};
      default: data1 = 8'h00;
    endcase
  end

  assign data2 = {4'd1, 4'd2};

  typedef struct {
    int    n;
    logic  sel, st, sp, pa, lp;
    int    addr, per, off;
    logic  busy, done;
    string tag;
  } seg_t;

  typedef struct {
    logic        sel;
    logic [11:0] want;
    string       tag;
  } exp_t;

  seg_t segs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic logic [11:0] obs(input logic sel);
    if (sel) return {6'd0, addr2, spk2, buz2, busy2, done2};
    return {addr1, spk1, buz1, busy1, done1};
  endfunction

  task automatic chk(input string tag, input logic [11:0] got,
                     input logic [11:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got addr=%0d spk=%b buz=%b busy=%b done=%b, want addr=%0d spk=%b buz=%b busy=%b done=%b",
               tag, got[11:4], got[3], got[2], got[1], got[0],
               want[11:4], want[3], want[2], want[1], want[0]);
    end
  endtask

  function automatic void add(input int n, input logic sel, st, sp, pa, lp,
                              input int addr, per, off,
                              input logic busy, done, input string tag);
    seg_t s;
    s.n = n; s.sel = sel; s.st = st; s.sp = sp; s.pa = pa; s.lp = lp;
    s.addr = addr; s.per = per; s.off = off;
    s.busy = busy; s.done = done; s.tag = tag;
    segs.push_back(s);
  endfunction

  // inputs apply to the next rising edge; expectation is the state after it
  task automatic step(input seg_t s, input int i);
    exp_t e;
    logic sp_exp;
    #1;
    start1  = s.st & ~s.sel;
    start2  = s.st & s.sel;
    stop    = s.sp;
    pause   = s.pa;
    loop_en = s.lp;
    sp_exp  = (s.per != 0) ? ((((i + s.off) / s.per) % 2) == 1) : 1'b0;
    e.sel   = s.sel;
    e.want  = {8'(s.addr), sp_exp, sp_exp, s.busy, s.done};
    e.tag   = $sformatf("%s[%0d]", s.tag, i);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk(e.tag, obs(e.sel), e.want);
  endtask

  task automatic run_segs();
    for (int j = 0; j < segs.size(); j++)
      for (int i = 0; i < segs[j].n; i++)
        step(segs[j], i);
    segs.delete();
  endtask

  initial begin
    rst = 1'b1;
    start1 = 1'b0; start2 = 1'b0;
    stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    #2;
    chk("reset_dut", obs(1'b0), 12'h000);
    chk("reset_wrap", obs(1'b1), 12'h000);
    @(negedge clk);
    #1 rst = 1'b0;

    // basic play
    add(1,  0, 1, 0, 0, 0, 0, 0, 0, 1, 0, "t1_start");
    add(20, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, "t1_note0");
    add(1,  0, 0, 0, 0, 0, 1, 0, 0, 1, 0, "t1_fetch1");
    add(10, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, "t1_rest");
    add(1,  0, 0, 0, 0, 0, 2, 0, 0, 1, 0, "t1_fetch2");
    add(1,  0, 0, 0, 0, 0, 2, 0, 0, 1, 1, "t1_end");
    add(3,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t1_idle");
    // loop mode
    add(1,  0, 1, 0, 0, 1, 0, 0, 0, 1, 0, "t2_start");
    add(20, 0, 0, 0, 0, 1, 0, 3, 0, 1, 0, "t2_note0");
    add(1,  0, 0, 0, 0, 1, 1, 0, 0, 1, 0, "t2_fetch1");
    add(10, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, "t2_rest");
    add(1,  0, 0, 0, 0, 1, 2, 0, 0, 1, 0, "t2_fetch2");
    add(1,  0, 0, 0, 0, 1, 2, 0, 0, 1, 0, "t2_end");
    add(1,  0, 0, 0, 0, 1, 0, 0, 0, 1, 0, "t2_refetch");
    add(12, 0, 0, 0, 0, 1, 0, 3, 0, 1, 0, "t2_replay");
    add(1,  0, 0, 1, 0, 1, 0, 0, 0, 0, 0, "t2_stop");
    add(2,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t2_idle");
    // pause
    add(1,  0, 1, 0, 0, 0, 0, 0, 0, 1, 0, "t3_start");
    add(8,  0, 0, 0, 0, 0, 0, 3, 0, 1, 0, "t3_pre");
    add(50, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, "t3_paused");
    add(13, 0, 0, 0, 0, 0, 0, 3, 7, 1, 0, "t3_resume");
    add(1,  0, 0, 0, 0, 0, 1, 0, 0, 1, 0, "t3_fetch1");
    add(1,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "t3_stop");
    // stop, stop+pause, start blocked by stop
    add(1,  0, 1, 0, 0, 0, 0, 0, 0, 1, 0, "t4_start");
    add(5,  0, 0, 0, 0, 0, 0, 3, 0, 1, 0, "t4_play");
    add(1,  0, 0, 1, 1, 0, 0, 0, 0, 0, 0, "t4_stop_pause");
    add(4,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "t4_start_blocked");
    add(2,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t4_idle");
    // address wrap on the 2-bit instance
    for (int n = 0; n < 4; n++) begin
      add(1,  1, n == 0, 0, 0, 0, n, 0, 0, 1, 0, "t6_fetch");
      add(10, 1, 0, 0, 0, 0, n, 2, 0, 1, 0, "t6_play");
    end
    add(1,  1, 0, 0, 0, 0, 3, 0, 0, 1, 1, "t6_end");
    add(5,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t6_idle");
    run_segs();

    // asynchronous reset mid-note while the speaker is high
    add(1,  0, 1, 0, 0, 0, 0, 0, 0, 1, 0, "t5_start");
    add(5,  0, 0, 0, 0, 0, 0, 3, 0, 1, 0, "t5_play");
    run_segs();
    #3 rst = 1'b1;
    #1 chk("t5_async_reset", obs(1'b0), 12'h000);
    @(posedge clk);
    #1 chk("t5_reset_held", obs(1'b0), 12'h000);
    @(negedge clk);
    #1 rst = 1'b0;
    add(2,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t5_idle");
    add(1,  0, 1, 0, 0, 0, 0, 0, 0, 1, 0, "t5_restart");
    add(6,  0, 0, 0, 0, 0, 0, 3, 0, 1, 0, "t5_replay");
    add(1,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "t5_stop");
    run_segs();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
